// File: rtl/div_arb.sv
`default_nettype none
// ============================================================================
// Module   : div_arb
// Purpose  : Two-port arbiter and sequencer for the shared multi-cycle EX
//            divider. Grants one requester at a time, drives the divider's
//            start/annul/sign/operand inputs, captures the 64-bit result and
//            always returns the divider to its free state (RELEASE after a
//            completion, DRAIN after a flush) before the next issue.
// Ports    : clk, rst (async, active-low)
//            req{0,1}_i, sign{0,1}_i, op1_{0,1}_i, op2_{0,1}_i, flush{0,1}_i
//                                       - requester side (port 0 = EX pipe)
//            stall{0,1}_o (comb), done{0,1}_o, result_o {rem, quot}
//            div_start_o, div_annul_o, div_sign_o, div_op1_o, div_op2_o,
//            div_result_i, div_ready_i  - divider side
//            busy_o                     - state is not IDLE
// Options  : DIV_ZERO_BYPASS_EN - answer divide-by-zero locally (result 0)
//            through a one-cycle ZERO state, never starting the divider.
// Revision : 1.0 - initial release
// ============================================================================
module div_arb #(
  parameter int ARB_MODE  = 0,  // 0 = round-robin, 1 = fixed priority port 0
  parameter int RR_INIT   = 0,  // port favoured first after reset
  parameter int DRAIN_CYC = 2   // annul cycles after a flush (>= 2)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic        sign0_i,
  input  logic        sign1_i,
  input  logic [31:0] op1_0_i,
  input  logic [31:0] op2_0_i,
  input  logic [31:0] op1_1_i,
  input  logic [31:0] op2_1_i,
  input  logic        flush0_i,
  input  logic        flush1_i,
  output logic        stall0_o,
  output logic        stall1_o,
  output logic        done0_o,
  output logic        done1_o,
  output logic [63:0] result_o,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_sign_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        busy_o
);

  // Counter only ever holds DRAIN_CYC-1 down to 0.
  localparam int CW = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BUSY    = 3'd1,
    S_RELEASE = 3'd2,
    S_DRAIN   = 3'd3,
    S_ZERO    = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          start_q, start_d;
  logic          annul_q, annul_d;
  logic          sign_q, sign_d;
  logic [31:0]   op1_q, op1_d;
  logic [31:0]   op2_q, op2_d;
  logic          done0_q, done0_d;
  logic          done1_q, done1_d;
  logic [63:0]   result_q, result_d;
  logic          busy_q;

  // Arbitration candidates: a flushed port is invisible to the arbiter.
  logic        v0, v1, gnt1;
  logic        own_req, own_flush;
  logic        sel_sign;
  logic [31:0] sel_op1, sel_op2;

  assign v0   = req0_i & ~flush0_i;
  assign v1   = req1_i & ~flush1_i;
  // Port 1 wins when alone, or on a tie only in round-robin with pointer on 1.
  assign gnt1 = (ARB_MODE == 1) ? (v1 & ~v0) : (v1 & (~v0 | ptr_q));

  assign sel_sign = gnt1 ? sign1_i : sign0_i;
  assign sel_op1  = gnt1 ? op1_1_i : op1_0_i;
  assign sel_op2  = gnt1 ? op2_1_i : op2_0_i;

  assign own_req   = owner_q ? req1_i   : req0_i;
  assign own_flush = owner_q ? flush1_i : flush0_i;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    start_d  = start_q;
    annul_d  = annul_q;
    sign_d   = sign_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        start_d = 1'b0;
        annul_d = 1'b0;
        if (v0 | v1) begin
          owner_d = gnt1;
          ptr_d   = ~gnt1;
          sign_d  = sel_sign;
          op1_d   = sel_op1;
          op2_d   = sel_op2;
`ifdef DIV_ZERO_BYPASS_EN
          if (sel_op2 == 32'd0) begin
            state_d = S_ZERO;
          end else begin
            start_d = 1'b1;
            state_d = S_BUSY;
          end
`else
          start_d = 1'b1;
          state_d = S_BUSY;
`endif
        end
      end

      S_BUSY: begin
        // Abandonment takes precedence over a same-cycle ready.
        if (own_flush | ~own_req) begin
          start_d = 1'b0;
          annul_d = 1'b1;
          cnt_d   = CW'(DRAIN_CYC - 1);
          state_d = S_DRAIN;
        end else if (div_ready_i) begin
          start_d  = 1'b0;
          result_d = div_result_i;
          done0_d  = ~owner_q;
          done1_d  = owner_q;
          state_d  = S_RELEASE;
        end
      end

      // One cycle with start low lets the divider fall back to free.
      S_RELEASE: begin
        start_d = 1'b0;
        state_d = S_IDLE;
      end

      S_DRAIN: begin
        start_d = 1'b0;
        if (cnt_q == '0) begin
          annul_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          annul_d = 1'b1;
          cnt_d   = cnt_q - CW'(1);
        end
      end

      // Locally answered divide-by-zero; the divider was never started.
      // Passing through RELEASE keeps the held request from re-arbitrating
      // during the done cycle.
      S_ZERO: begin
        start_d = 1'b0;
        if (own_flush | ~own_req) begin
          state_d = S_IDLE;
        end else begin
          result_d = 64'd0;
          done0_d  = ~owner_q;
          done1_d  = owner_q;
          state_d  = S_RELEASE;
        end
      end

      default: begin
        start_d = 1'b0;
        annul_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      ptr_q    <= (RR_INIT != 0);
      cnt_q    <= '0;
      start_q  <= 1'b0;
      annul_q  <= 1'b0;
      sign_q   <= 1'b0;
      op1_q    <= 32'd0;
      op2_q    <= 32'd0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      result_q <= 64'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      annul_q  <= annul_d;
      sign_q   <= sign_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      result_q <= result_d;
      busy_q   <= (state_d != S_IDLE);
    end
  end

  assign stall0_o    = req0_i & ~done0_q & ~flush0_i;
  assign stall1_o    = req1_i & ~done1_q & ~flush1_i;
  assign done0_o     = done0_q;
  assign done1_o     = done1_q;
  assign result_o    = result_q;
  assign div_start_o = start_q;
  assign div_annul_o = annul_q;
  assign div_sign_o  = sign_q;
  assign div_op1_o   = op1_q;
  assign div_op2_o   = op2_q;
  assign busy_o      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_div_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_arb
// Purpose  : Directed self-checking bench for div_arb with a behavioural
//            fixed-latency divider attached to the divider-side ports.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_arb;
  localparam int LAT = 16;  // divider cycles from first start-high edge to ready

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_i = 1'b0, req1_i = 1'b0;
  logic        sign0_i = 1'b0, sign1_i = 1'b0;
  logic [31:0] op1_0_i = '0, op2_0_i = '0, op1_1_i = '0, op2_1_i = '0;
  logic        flush0_i = 1'b0, flush1_i = 1'b0;
  logic        stall0_o, stall1_o, done0_o, done1_o;
  logic [63:0] result_o;
  logic        div_start_o, div_annul_o, div_sign_o;
  logic [31:0] div_op1_o, div_op2_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        busy_o;

  int checks = 0;
  int failures = 0;
  int n;
  logic saw_start;

  always #5 clk = ~clk;

  div_arb dut (
    .clk(clk), .rst(rst),
    .req0_i(req0_i), .req1_i(req1_i),
    .sign0_i(sign0_i), .sign1_i(sign1_i),
    .op1_0_i(op1_0_i), .op2_0_i(op2_0_i),
    .op1_1_i(op1_1_i), .op2_1_i(op2_1_i),
    .flush0_i(flush0_i), .flush1_i(flush1_i),
    .stall0_o(stall0_o), .stall1_o(stall1_o),
    .done0_o(done0_o), .done1_o(done1_o),
    .result_o(result_o),
    .div_start_o(div_start_o), .div_annul_o(div_annul_o),
    .div_sign_o(div_sign_o),
    .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i),
    .busy_o(busy_o)
  );

  // Behavioural divider: counts while start is high, raises ready with the
  // result after LAT edges, returns 0 for a zero divisor, clears on start
  // low or annul.
  logic [4:0] mcnt;
  function automatic logic [63:0] div_model(input logic s, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcnt <= '0; div_ready_i <= 1'b0; div_result_i <= '0;
    end else if (!div_start_o || div_annul_o) begin
      mcnt <= '0; div_ready_i <= 1'b0;
    end else if (!div_ready_i) begin
      if (mcnt == 5'(LAT - 1)) begin
        div_ready_i  <= 1'b1;
        div_result_i <= div_model(div_sign_o, div_op1_o, div_op2_o);
      end else begin
        mcnt <= mcnt + 5'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int port, input int budget, output int cnt);
    cnt = 0;
    while (cnt < budget) begin
      tick();
      cnt++;
      if ((port == 0 && done0_o) || (port == 1 && done1_o)) break;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy",   64'(busy_o), 64'd0);
    chk("rst_start",  64'(div_start_o), 64'd0);
    chk("rst_annul",  64'(div_annul_o), 64'd0);
    chk("rst_result", result_o, 64'd0);
    rst = 1'b1;
    tick();

    // ---------------- unsigned 100/7 on port 0
    req0_i = 1; sign0_i = 0; op1_0_i = 32'd100; op2_0_i = 32'd7; #1;
    chk("t1_stall0", 64'(stall0_o), 64'd1);
    tick();
    chk("t1_start_rise", 64'(div_start_o), 64'd1);
    chk("t1_op1", 64'(div_op1_o), 64'd100);
    chk("t1_op2", 64'(div_op2_o), 64'd7);
    wait_done(0, 40, n);
    chk("t1_done", 64'(done0_o), 64'd1);
    chk("t1_result", result_o, {32'd2, 32'd14});
    chk("t1_release_start", 64'(div_start_o), 64'd0);
    chk("t1_stall_at_done", 64'(stall0_o), 64'd0);
    req0_i = 0;
    tick();
    chk("t1_done_pulse", 64'(done0_o), 64'd0);
    chk("t1_idle", 64'(busy_o), 64'd0);

    // ---------------- signed -7/2 on port 1
    req1_i = 1; sign1_i = 1; op1_1_i = 32'hFFFF_FFF9; op2_1_i = 32'd2;
    tick();
    chk("t2_sign", 64'(div_sign_o), 64'd1);
    repeat (5) tick();
    chk("t2_stall1", 64'(stall1_o), 64'd1);
    wait_done(1, 40, n);
    chk("t2_done", 64'(done1_o), 64'd1);
    chk("t2_result", result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    req1_i = 0; sign1_i = 0;
    tick();

    // ---------------- simultaneous pair, pointer back on port 0
    req0_i = 1; op1_0_i = 32'd20; op2_0_i = 32'd3;
    req1_i = 1; op1_1_i = 32'd50; op2_1_i = 32'd5;
    tick();
    chk("t3_port0_first", 64'(div_op1_o), 64'd20);
    wait_done(0, 40, n);
    chk("t3_done0", 64'(done0_o), 64'd1);
    chk("t3_result0", result_o, {32'd2, 32'd6});
    chk("t3_stall1_waiting", 64'(stall1_o), 64'd1);
    req0_i = 0;
    tick();
    chk("t3_idle_start", 64'(div_start_o), 64'd0);
    tick();
    chk("t3_port1_start", 64'(div_start_o), 64'd1);
    chk("t3_port1_op1", 64'(div_op1_o), 64'd50);
    wait_done(1, 40, n);
    chk("t3_done1", 64'(done1_o), 64'd1);
    chk("t3_result1", result_o, {32'd0, 32'd10});
    req1_i = 0;
    tick();

    // single port-0 grant moves the pointer to port 1
    req0_i = 1; op1_0_i = 32'd9; op2_0_i = 32'd4;
    wait_done(0, 40, n);
    chk("t3b_result", result_o, {32'd1, 32'd2});
    req0_i = 0;
    tick();

    // second simultaneous pair: port 1 favoured
    req0_i = 1; op1_0_i = 32'd30; op2_0_i = 32'd4;
    req1_i = 1; op1_1_i = 32'd8;  op2_1_i = 32'd3;
    tick();
    chk("t3c_port1_first", 64'(div_op1_o), 64'd8);
    wait_done(1, 40, n);
    chk("t3c_result1", result_o, {32'd2, 32'd2});
    req1_i = 0;
    tick();
    tick();
    chk("t3c_port0_op1", 64'(div_op1_o), 64'd30);
    wait_done(0, 40, n);
    chk("t3c_result0", result_o, {32'd2, 32'd7});
    req0_i = 0;
    tick();

    // ---------------- flush 10 cycles into BUSY
    req0_i = 1; op1_0_i = 32'd1000; op2_0_i = 32'd10;
    tick();
    repeat (10) tick();
    chk("t4_busy_start", 64'(div_start_o), 64'd1);
    flush0_i = 1; #1;
    chk("t4_stall_masked", 64'(stall0_o), 64'd0);
    tick();
    chk("t4_annul1", 64'(div_annul_o), 64'd1);
    chk("t4_start_low1", 64'(div_start_o), 64'd0);
    chk("t4_no_done1", 64'(done0_o), 64'd0);
    flush0_i = 0; req0_i = 0;
    tick();
    chk("t4_annul2", 64'(div_annul_o), 64'd1);
    chk("t4_no_done2", 64'(done0_o), 64'd0);
    tick();
    chk("t4_annul_end", 64'(div_annul_o), 64'd0);
    chk("t4_idle", 64'(busy_o), 64'd0);
    chk("t4_result_kept", result_o, {32'd2, 32'd7});
    req0_i = 1; op1_0_i = 32'd77; op2_0_i = 32'd7;
    wait_done(0, 40, n);
    chk("t4_next_done", 64'(done0_o), 64'd1);
    chk("t4_next_result", result_o, {32'd0, 32'd11});
    req0_i = 0;
    tick();

    // ---------------- flush coincident with div_ready_i
    req0_i = 1; op1_0_i = 32'd45; op2_0_i = 32'd6;
    n = 0;
    tick();
    while (n < 40 && !div_ready_i) begin tick(); n++; end
    chk("t5_ready_seen", 64'(div_ready_i), 64'd1);
    flush0_i = 1;
    tick();
    chk("t5_drain_annul", 64'(div_annul_o), 64'd1);
    chk("t5_no_done", 64'(done0_o), 64'd0);
    flush0_i = 0; req0_i = 0;
    tick();
    chk("t5_no_done2", 64'(done0_o), 64'd0);
    tick();
    chk("t5_idle", 64'(busy_o), 64'd0);
    chk("t5_result_kept", result_o, {32'd0, 32'd11});

    // ---------------- divide by zero
    req0_i = 1; op1_0_i = 32'd5; op2_0_i = 32'd0;
    n = 0; saw_start = 0;
    while (n < 60 && !done0_o) begin
      tick(); n++;
      if (div_start_o) saw_start = 1;
    end
    chk("t6_done", 64'(done0_o), 64'd1);
    chk("t6_result_zero", result_o, 64'd0);
`ifdef DIV_ZERO_BYPASS_EN
    chk("t6_latency", 64'(n), 64'd2);
    chk("t6_never_started", 64'(saw_start), 64'd0);
`else
    chk("t6_latency", 64'(n), 64'(LAT + 2));
    chk("t6_started", 64'(saw_start), 64'd1);
`endif
    req0_i = 0;
    tick();

    // ---------------- reset mid-operation
    req1_i = 1; op1_1_i = 32'd12; op2_1_i = 32'd5;
    repeat (4) tick();
    chk("t7_busy_before", 64'(busy_o), 64'd1);
    rst = 1'b0; #1;
    chk("t7_busy_reset", 64'(busy_o), 64'd0);
    chk("t7_start_reset", 64'(div_start_o), 64'd0);
    chk("t7_result_reset", result_o, 64'd0);
    req1_i = 0;
    tick();
    rst = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_arb.md
Name: div_arb

Overview:
- Two-port arbiter and sequencer for the shared multi-cycle divider in the EX stage.
- Port 0 is the main pipeline EX; port 1 is the auxiliary requester (coprocessor/debug).
- Grants one requester at a time, drives the divider's start/annul/sign/operand inputs and captures the 64-bit result.
- Returns the divider to its free state after every completion or flush, so the divider is always idle before the next issue.

Parameters:
ARB_MODE, 0, 0 = round-robin between ports, 1 = fixed priority with port 0 winning
RR_INIT, 0, port favoured first after reset in round-robin mode
DRAIN_CYC, 2, cycles of annul/start-low held after a flush (must be >= 2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
req0_i / req1_i  in  1  division request; held with operands stable until done or flush
sign0_i / sign1_i  in  1  1 = signed (div), 0 = unsigned (divu)
op1_0_i, op2_0_i / op1_1_i, op2_1_i  in  32 each  dividend, divisor
flush0_i / flush1_i  in  1  abandon this port's request
stall0_o / stall1_o  out  1  request pending and not yet done
done0_o / done1_o  out  1  one-cycle completion pulse
result_o  out  64  {remainder, quotient}; valid with done, held until next done
div_start_o  out  1  divider start
div_annul_o  out  1  divider annul
div_sign_o  out  1  divider signed select
div_op1_o, div_op2_o  out  32 each  divider operands
div_result_i  in  64  divider result
div_ready_i  in  1  divider result ready
busy_o  out  1  state is not IDLE

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; result_o 0; round-robin pointer = RR_INIT.
- stallN_o = reqN_i & ~doneN_o & ~flushN_i (combinational). All other outputs are registered.
- States:
  - IDLE: if any reqN_i & ~flushN_i, arbitrate.
    - Round-robin: the favoured port wins a tie; the pointer moves to the other port after each grant.
    - ARB_MODE=1: port 0 always wins a tie.
    - Latch owner, sign and operands; next cycle div_start_o=1 with operands driven; go BUSY.
  - BUSY: div_start_o=1, operands held from latch (requester changes ignored).
    - div_ready_i=1: capture div_result_i into result_o, pulse done<owner>_o next cycle, go RELEASE.
    - flush<owner>_i=1, or req<owner>_i deasserted: go DRAIN.
  - RELEASE: div_start_o=0 for exactly 1 cycle so the divider returns to free; go IDLE. A new grant can occur in the following IDLE cycle.
  - DRAIN: div_start_o=0, div_annul_o=1 for DRAIN_CYC cycles (counter), then IDLE. No done pulse; result_o unchanged. This covers the divider in its running, divide-by-zero and end states.
- Flush and div_ready_i in the same cycle: flush wins, result discarded, go DRAIN.
- Flush of a non-owner port: only masks its stall/arbitration; no effect on the divider.
- A request arriving while BUSY waits. Its stall stays high; it is arbitrated in the next IDLE.
- Divisor = 0: issued normally; the divider returns 0; done pulses with result_o=0.
- Reset mid-operation: immediately IDLE, outputs 0. The divider shares the reset, so no drain is needed.

Optional Feature:
- Macro DIV_ZERO_BYPASS_EN.
- Defined: in IDLE, a granted request with op2=0 is not issued to the divider (div_start_o stays 0). doneN_o pulses 2 cycles after the grant with result_o=0; the state passes through a 1-cycle ZERO state. The round-robin pointer advances as normal.
- Undefined: divide-by-zero goes through the divider as above.

Test Plan:
- Unsigned 100/7 on port 0 -> div_start_o rises 1 cycle after req; done0_o within 40 cycles; result_o={32'd2, 32'd14}; one RELEASE cycle with start low.
- Signed -7/2 on port 1 -> result_o={32'hFFFFFFFF, 32'hFFFFFFFD}; stall1_o high until done1_o.
- Both requests asserted in the same cycle, round-robin, RR_INIT=0 -> port 0 served first, port 1 issued right after port 0's RELEASE; second pair of simultaneous requests -> port 1 served first.
- flush0_i 10 cycles into BUSY -> div_annul_o=1, div_start_o=0 for 2 cycles, no done0_o, result_o unchanged; next request completes correctly.
- Flush in the same cycle as div_ready_i -> no done pulse, DRAIN entered.
- op2=0: without macro -> done after full divider latency, result 0; with DIV_ZERO_BYPASS_EN -> done 2 cycles after grant, div_start_o never asserted.
